// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit Wishbone master.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } lsu_state_e;

  // Number of byte-lane address bits for a given data width.
  function automatic int unsigned lane_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: select/write-data generation, alignment and
// legality checks, and load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]                   op_i,
  input  logic                         write_i,
  input  logic [lane_bits(DATA_W)-1:0] off_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [2:0]                   rd_op_i,
  input  logic [lane_bits(DATA_W)-1:0] rd_off_i,
  input  logic [DATA_W-1:0]            rd_data_i,
  output logic [DATA_W/8-1:0]          sel_o,
  output logic [DATA_W-1:0]            wdata_o,
  output logic                         misaligned_o,
  output logic                         illegal_o,
  output logic [DATA_W-1:0]            rdata_o
);

  localparam int unsigned SEL_W = DATA_W / 8;

  logic              mis_raw;
  logic [DATA_W-1:0] rd_shift;

  // Size decode from the low two op bits drives both selects and alignment.
  always_comb begin
    sel_o   = '0;
    mis_raw = 1'b0;
    case (op_i[1:0])
      2'b00: sel_o = SEL_W'(1) << off_i;
      2'b01: begin
        sel_o   = SEL_W'(3) << off_i;
        mis_raw = off_i[0];
      end
      2'b10: begin
        sel_o   = SEL_W'(15) << off_i;
        mis_raw = |off_i[1:0];
      end
      default: begin
        sel_o   = '1;
        mis_raw = |off_i;
      end
    endcase
  end

  always_comb begin
    illegal_o = 1'b0;
    if (DATA_W == 64) begin
      illegal_o = (op_i == 3'b111) || (write_i && op_i[2]);
    end else begin
      illegal_o = (op_i == 3'b011) || (op_i == 3'b110) || (op_i == 3'b111);
    end
  end

  // An illegal op reports as an access fault, never as misaligned.
  assign misaligned_o = mis_raw && !illegal_o;
  assign wdata_o      = wdata_i << {off_i, 3'b000};
  assign rd_shift     = rd_data_i >> {rd_off_i, 3'b000};

  always_comb begin
    rdata_o = rd_shift;
    case (mem_op_e'(rd_op_i))
      LB:      rdata_o = DATA_W'($signed(rd_shift[7:0]));
      LH:      rdata_o = DATA_W'($signed(rd_shift[15:0]));
      LW:      rdata_o = DATA_W'($signed(rd_shift[31:0]));
      LBU:     rdata_o = DATA_W'(rd_shift[7:0]);
      LHU:     rdata_o = DATA_W'(rd_shift[15:0]);
      LWU:     rdata_o = DATA_W'(rd_shift[31:0]);
      default: rdata_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// MEM-stage load/store unit driving a Wishbone B4 classic master port.
// Optional bus timeout abort enabled by defining LSU_WB_TIMEOUT_EN.
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                stall,
  output logic                misaligned,
  output logic                bus_err,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  localparam int unsigned LANE_W = lane_bits(DATA_W);
  localparam int unsigned SEL_W  = DATA_W / 8;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("lsu_wb_master: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lsu_wb_master: TIMEOUT_CYCLES must be 1..65535");
  end

  lsu_state_e        state_q, state_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [2:0]        op_q, op_d;
  logic [LANE_W-1:0] off_q, off_d;

  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] wdata_c, rdata_c;
  logic              mis_c, ill_c, start_c, timeout_c;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .op_i        (req_op),
    .write_i     (req_write),
    .off_i       (req_addr[LANE_W-1:0]),
    .wdata_i     (req_wdata),
    .rd_op_i     (op_q),
    .rd_off_i    (off_q),
    .rd_data_i   (wb_dat_i),
    .sel_o       (sel_c),
    .wdata_o     (wdata_c),
    .misaligned_o(mis_c),
    .illegal_o   (ill_c),
    .rdata_o     (rdata_c)
  );

  assign start_c = req_valid && !mis_c && !ill_c;

`ifdef LSU_WB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // BUS is only entered from IDLE, so holding the count at zero there clears it on entry.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (state_q == BUS) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_c = (state_q == BUS) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    op_d      = op_q;
    off_d     = off_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = req_write;
          adr_d   = req_addr & ~ADDR_W'(SEL_W - 1);
          dat_d   = wdata_c;
          sel_d   = sel_c;
          op_d    = req_op;
          off_d   = req_addr[LANE_W-1:0];
          state_d = BUS;
        end
      end
      BUS: begin
        // Error (or timeout) takes priority over a simultaneous ack.
        if (wb_err_i || timeout_c) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rdata_d = rdata_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      op_q      <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      op_q      <= op_d;
      off_q     <= off_d;
    end
  end

  // Exceptions raised in IDLE are combinational so they belong to the current instruction.
  assign stall      = !reset && (((state_q == IDLE) && start_c) || (state_q == BUS));
  assign misaligned = !reset && (state_q == IDLE) && req_valid && mis_c;
  assign bus_err    = bus_err_q || (!reset && (state_q == IDLE) && req_valid && ill_c);

  assign resp_rdata = rdata_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed, table-driven bench for lsu_wb_master (32-bit and 64-bit instances).
module tb_lsu_wb_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // 32-bit instance
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] resp_rdata;
  logic        stall, misaligned, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

  // 64-bit instance
  logic        x_valid = 1'b0, x_write = 1'b0;
  logic [2:0]  x_op = '0;
  logic [31:0] x_addr = '0;
  logic [63:0] x_wdata = '0;
  logic [63:0] x_rdata;
  logic        x_stall, x_mis, x_berr;
  logic        x_cyc, x_stb, x_we;
  logic [31:0] x_adr;
  logic [63:0] x_dat_o;
  logic [7:0]  x_sel;
  logic [63:0] x_dat_i = '0;
  logic        x_ack = 1'b0, x_err = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(255)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_rdata(resp_rdata),
    .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  lsu_wb_master #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(255)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(x_valid), .req_write(x_write), .req_op(x_op),
    .req_addr(x_addr), .req_wdata(x_wdata), .resp_rdata(x_rdata),
    .stall(x_stall), .misaligned(x_mis), .bus_err(x_berr),
    .wb_cyc_o(x_cyc), .wb_stb_o(x_stb), .wb_we_o(x_we),
    .wb_adr_o(x_adr), .wb_dat_o(x_dat_o), .wb_sel_o(x_sel),
    .wb_dat_i(x_dat_i), .wb_ack_i(x_ack), .wb_err_i(x_err)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          waitc;
    logic        err;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic wr, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdat, input int waitc, input logic err,
                              input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [31:0] rdata,
                              input logic mis, input logic ill);
    vec_t v;
    v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata; v.rdat = rdat;
    v.waitc = waitc; v.err = err; v.sel = sel; v.adr = adr; v.dat = dat;
    v.rdata = rdata; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    int    stall_n;
    p = $sformatf("v%0d", idx);
    req_valid = 1'b1; req_write = v.wr; req_op = v.op;
    req_addr = v.addr; req_wdata = v.wdata;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #1;
    check({p, " misaligned"}, 64'(misaligned), 64'(v.mis));
    check({p, " bus_err_idle"}, 64'(bus_err), 64'(v.ill));
    if (v.mis || v.ill) begin
      check({p, " stall_reject"}, 64'(stall), 64'd0);
      req_valid = 1'b0;
      tick();
      check({p, " cyc_reject"}, 64'(wb_cyc_o), 64'd0);
      check({p, " bus_err_pulse"}, 64'(bus_err), 64'd0);
      return;
    end
    stall_n = stall ? 1 : 0;
    tick();
    check({p, " cyc"}, 64'(wb_cyc_o), 64'd1);
    check({p, " stb"}, 64'(wb_stb_o), 64'd1);
    check({p, " we"}, 64'(wb_we_o), 64'(v.wr));
    check({p, " adr"}, 64'(wb_adr_o), 64'(v.adr));
    check({p, " sel"}, 64'(wb_sel_o), 64'(v.sel));
    check({p, " dat"}, 64'(wb_dat_o), 64'(v.dat));
    for (int k = 0; k < v.waitc; k++) begin
      if (stall) stall_n++;
      tick();
      check({p, " cyc_wait"}, 64'(wb_cyc_o), 64'd1);
    end
    if (stall) stall_n++;
    wb_dat_i = v.rdat;
    if (v.err) wb_err_i = 1'b1; else wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    check({p, " stall_cycles"}, 64'(stall_n), 64'(2 + v.waitc));
    check({p, " stall_done"}, 64'(stall), 64'd0);
    check({p, " cyc_done"}, 64'(wb_cyc_o), 64'd0);
    check({p, " bus_err_done"}, 64'(bus_err), 64'(v.err));
    check({p, " rdata"}, 64'(resp_rdata), 64'(v.rdata));
    tick();
    check({p, " no_restart"}, 64'(wb_cyc_o), 64'd0);
    req_valid = 1'b0;
    #1;
    check({p, " idle_err"}, 64'(bus_err), 64'd0);
  endtask

  task automatic run64(input string name, input logic [2:0] op, input logic [31:0] addr,
                       input logic [63:0] rdat, input logic [7:0] exp_sel,
                       input logic [63:0] exp_rdata);
    x_valid = 1'b1; x_write = 1'b0; x_op = op; x_addr = addr;
    #1;
    check({name, " stall"}, 64'(x_stall), 64'd1);
    tick();
    check({name, " cyc"}, 64'(x_cyc), 64'd1);
    check({name, " sel"}, 64'(x_sel), 64'(exp_sel));
    check({name, " adr"}, 64'(x_adr), 64'(addr & ~32'h7));
    x_ack = 1'b1; x_dat_i = rdat;
    tick();
    x_ack = 1'b0;
    check({name, " rdata"}, x_rdata, exp_rdata);
    tick();
    x_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1, 0, 4'hF, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
    vecs[1]  = mk(0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 0, 4'h8, 32'h200, 32'h0, 32'hFFFFFF80, 0, 0);
    vecs[2]  = mk(0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, 0, 4'h8, 32'h200, 32'h0, 32'h00000080, 0, 0);
    vecs[3]  = mk(1, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    vecs[4]  = mk(0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 1, 4'hF, 32'h300, 32'h0, 32'h0, 0, 0);
    vecs[5]  = mk(0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1);
    vecs[6]  = mk(0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 0, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 0, 0);
    vecs[7]  = mk(0, 3'b101, 32'h102, 32'h0, 32'h80010000, 2, 0, 4'hC, 32'h100, 32'h0, 32'h00008001, 0, 0);
    vecs[8]  = mk(1, 3'b000, 32'h105, 32'h000000AB, 32'h0, 0, 0, 4'h2, 32'h104, 32'h0000AB00, 32'h0, 0, 0);
    vecs[9]  = mk(1, 3'b001, 32'h106, 32'h00001234, 32'h0, 0, 0, 4'hC, 32'h104, 32'h12340000, 32'h0, 0, 0);
    vecs[10] = mk(0, 3'b010, 32'h112, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    vecs[11] = mk(0, 3'b110, 32'h000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1);
    vecs[12] = mk(1, 3'b111, 32'h000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1);
    vecs[13] = mk(0, 3'b010, 32'h008, 32'h0, 32'h7FFF0001, 3, 0, 4'hF, 32'h008, 32'h0, 32'h7FFF0001, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst cyc", 64'(wb_cyc_o), 64'd0);
    check("rst stb", 64'(wb_stb_o), 64'd0);
    check("rst we", 64'(wb_we_o), 64'd0);
    check("rst adr", 64'(wb_adr_o), 64'd0);
    check("rst dat", 64'(wb_dat_o), 64'd0);
    check("rst sel", 64'(wb_sel_o), 64'd0);
    check("rst rdata", 64'(resp_rdata), 64'd0);
    check("rst bus_err", 64'(bus_err), 64'd0);
    check("rst stall", 64'(stall), 64'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // ack and err together: err wins
    req_valid = 1'b1; req_write = 1'b0; req_op = 3'b010; req_addr = 32'h40;
    tick();
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h55;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check("ackerr bus_err", 64'(bus_err), 64'd1);
    check("ackerr rdata", 64'(resp_rdata), 64'd0);
    check("ackerr cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    req_valid = 1'b0;

    // request withdrawn and changed mid-BUS: transaction completes as issued
    req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h20;
    tick();
    req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h3;
    #1;
    check("drop stall", 64'(stall), 64'd1);
    check("drop adr", 64'(wb_adr_o), 64'h20);
    check("drop sel", 64'(wb_sel_o), 64'hF);
    wb_ack_i = 1'b1; wb_dat_i = 32'h80000000;
    tick();
    wb_ack_i = 1'b0;
    check("drop rdata", 64'(resp_rdata), 64'h80000000);
    tick();

    // reset during BUS, then a late ack
    req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h44;
    tick();
    check("rstbus cyc_pre", 64'(wb_cyc_o), 64'd1);
    reset = 1'b1; req_valid = 1'b0;
    tick();
    reset = 1'b0;
    check("rstbus cyc", 64'(wb_cyc_o), 64'd0);
    check("rstbus stb", 64'(wb_stb_o), 64'd0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
    tick();
    wb_ack_i = 1'b0;
    check("late ack rdata", 64'(resp_rdata), 64'd0);
    check("late ack bus_err", 64'(bus_err), 64'd0);
    check("late ack stall", 64'(stall), 64'd0);
    check("late ack cyc", 64'(wb_cyc_o), 64'd0);

    // 64-bit data path
    run64("ld64", 3'b011, 32'h10, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF);
    run64("lw64", 3'b010, 32'h14, 64'h8000000000000000, 8'hF0, 64'hFFFFFFFF80000000);
    run64("lwu64", 3'b110, 32'h14, 64'h8000000000000000, 8'hF0, 64'h0000000080000000);
    run64("lb64", 3'b000, 32'h17, 64'hA500000000000000, 8'h80, 64'hFFFFFFFFFFFFFFA5);

    x_valid = 1'b1; x_write = 1'b1; x_op = 3'b100; x_addr = 32'h0;
    #1;
    check("st64 illegal bus_err", 64'(x_berr), 64'd1);
    check("st64 illegal stall", 64'(x_stall), 64'd0);
    x_valid = 1'b0;
    tick();
    check("st64 illegal cyc", 64'(x_cyc), 64'd0);

    x_valid = 1'b1; x_write = 1'b0; x_op = 3'b011; x_addr = 32'h14;
    #1;
    check("ld64 misaligned", 64'(x_mis), 64'd1);
    check("ld64 mis stall", 64'(x_stall), 64'd0);
    x_valid = 1'b0;
    tick();
    check("ld64 mis cyc", 64'(x_cyc), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
